// File: rtl/data_mem_responder.sv
// Data-memory target for the load/store unit: one outstanding request, fixed-latency
// access to a word array, RV32I load extension and error reporting on the response.
module data_mem_responder #(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_funct3,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          we_q, we_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [2:0]    f3_q, f3_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          err_q, err_d;

    // Array is deliberately left out of reset; only control state is cleared.
    logic [31:0]   mem [DEPTH];

    logic [AW-1:0] idx;
    logic [1:0]    lane;
    logic [31:0]   cur, merged, ld;
    logic [7:0]    sel_b;
    logic [15:0]   sel_h;
    logic          err, do_access, mem_we;

    assign idx  = addr_q[AW+1:2];
    assign lane = addr_q[1:0];
    assign cur  = mem[idx];

    always_comb begin
        err = 1'b0;
        case (f3_q)
            3'b000:         err = 1'b0;
            3'b001:         err = lane[0];
            3'b010:         err = |lane;
            3'b100, 3'b101: err = we_q | (f3_q[0] & lane[0]);
            default:        err = 1'b1;
        endcase
        if (addr_q[31:AW+2] != '0) err = 1'b1;
    end

    always_comb begin
        sel_b = cur[{lane, 3'b000} +: 8];
        sel_h = lane[1] ? cur[31:16] : cur[15:0];
        case (f3_q)
            3'b000:  ld = {{24{sel_b[7]}}, sel_b};
            3'b001:  ld = {{16{sel_h[15]}}, sel_h};
            3'b010:  ld = cur;
            3'b100:  ld = {24'd0, sel_b};
            3'b101:  ld = {16'd0, sel_h};
            default: ld = 32'd0;
        endcase
    end

    // Read-modify-write merge so untouched byte lanes keep their contents.
    always_comb begin
        merged = cur;
        case (f3_q[1:0])
            2'b00:   merged[{lane, 3'b000} +: 8]      = wdata_q[7:0];
            2'b01:   merged[{lane[1], 4'b0000} +: 16] = wdata_q[15:0];
            default: merged = wdata_q;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        f3_d      = f3_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        do_access = 1'b0;
        case (state_q)
            IDLE: if (req_valid) begin
                we_d    = req_we;
                addr_d  = req_addr;
                wdata_d = req_wdata;
                f3_d    = req_funct3;
                cnt_d   = CW'(LATENCY - 1);
                state_d = WAIT;
            end
            WAIT: if (cnt_q != '0) begin
                cnt_d = cnt_q - 1'b1;
            end else begin
                do_access = 1'b1;
                err_d     = err;
                rdata_d   = (err || we_q) ? 32'd0 : ld;
                state_d   = RESP;
            end
            RESP: if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign mem_we = do_access & we_q & ~err;

    always_ff @(posedge clk) begin
        if (mem_we) mem[idx] <= merged;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            f3_q    <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            f3_q    <= f3_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;
endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench: expected {err, rdata} pushed at issue, popped when the response appears.
module tb_data_mem_responder;
    localparam int DEPTH   = 1024;
    localparam int LATENCY = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [2:0]  req_funct3 = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int n_cmp = 0;
    int n_bad = 0;
    logic [32:0] sb_q[$];

    data_mem_responder #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_funct3(req_funct3),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Full transaction; hold = cycles to keep rsp_ready low once rsp_valid is seen.
    task automatic xact(input string tag, input logic we, input logic [31:0] a,
                        input logic [31:0] wd, input logic [2:0] f3,
                        input logic [31:0] exp_d, input logic exp_e, input int hold);
        int n;
        logic [32:0] e;
        logic [31:0] held;
        sb_q.push_back({exp_e, exp_d});
        @(negedge clk);
        n = 0;
        while (!req_ready && n < 50) begin @(negedge clk); n++; end
        chk({tag, "_ready"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = wd; req_funct3 = f3;
        if (hold > 0) rsp_ready = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b0; req_wdata = 32'hBAD0BAD0; req_addr = 32'hFFFF_FFFF;
        n = 0;
        while (!rsp_valid && n < 20) begin @(posedge clk); #1; n++; end
        chk({tag, "_lat"}, 32'(n), 32'(LATENCY));
        e = sb_q.pop_front();
        chk({tag, "_data"}, rsp_rdata, e[31:0]);
        chk({tag, "_err"}, 32'(rsp_err), 32'(e[32]));
        if (hold > 0) begin
            held = rsp_rdata;
            for (int i = 0; i < hold; i++) begin
                @(posedge clk); #1;
                chk({tag, "_bp_valid"}, 32'(rsp_valid), 32'd1);
                chk({tag, "_bp_data"}, rsp_rdata, held);
                chk({tag, "_bp_ready"}, 32'(req_ready), 32'd0);
            end
            rsp_ready = 1'b1;
        end
        @(posedge clk); #1;
        chk({tag, "_done_valid"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_done_ready"}, 32'(req_ready), 32'd1);
    endtask

    initial begin
        #1;
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_valid", 32'(rsp_valid), 32'd0);
        chk("rst_data",  rsp_rdata, 32'd0);
        chk("rst_err",   32'(rsp_err), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        xact("sw10",  1, 32'h10, 32'hDEADBEEF, 3'b010, 32'd0, 0, 0);
        xact("lw10",  0, 32'h10, 32'd0, 3'b010, 32'hDEADBEEF, 0, 0);
        xact("lb13",  0, 32'h13, 32'd0, 3'b000, 32'hFFFFFFDE, 0, 0);
        xact("lbu13", 0, 32'h13, 32'd0, 3'b100, 32'h000000DE, 0, 0);
        xact("lh10",  0, 32'h10, 32'd0, 3'b001, 32'hFFFFBEEF, 0, 0);
        xact("lhu12", 0, 32'h12, 32'd0, 3'b101, 32'h0000DEAD, 0, 0);
        xact("sb11",  1, 32'h11, 32'h12345677, 3'b000, 32'd0, 0, 0);
        xact("lw_sb", 0, 32'h10, 32'd0, 3'b010, 32'hDEAD77EF, 0, 0);
        xact("sh12",  1, 32'h12, 32'h0000A5A5, 3'b001, 32'd0, 0, 0);
        xact("lw_sh", 0, 32'h10, 32'd0, 3'b010, 32'hA5A577EF, 0, 0);

        xact("e_lw12",  0, 32'h12, 32'd0, 3'b010, 32'd0, 1, 0);
        xact("e_lh11",  0, 32'h11, 32'd0, 3'b001, 32'd0, 1, 0);
        xact("e_sw_oob", 1, 32'(4*DEPTH), 32'h1, 3'b010, 32'd0, 1, 0);
        xact("e_f011",  0, 32'h10, 32'd0, 3'b011, 32'd0, 1, 0);
        xact("e_sbu",   1, 32'h10, 32'hFFFFFFFF, 3'b100, 32'd0, 1, 0);
        xact("e_shu",   1, 32'h10, 32'hFFFFFFFF, 3'b101, 32'd0, 1, 0);
        xact("lw_keep", 0, 32'h10, 32'd0, 3'b010, 32'hA5A577EF, 0, 0);
        xact("lbu_oob", 0, 32'(4*DEPTH+3), 32'd0, 3'b100, 32'd0, 1, 0);

        xact("bp_lw", 0, 32'h10, 32'd0, 3'b010, 32'hA5A577EF, 0, 5);

        // Reset in the middle of a store's wait: the store must not land.
        xact("sw20_0", 1, 32'h20, 32'd0, 3'b010, 32'd0, 0, 0);
        xact("lw13_nz", 0, 32'h13, 32'd0, 3'b000, 32'hFFFFFFA5, 0, 0);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20;
        req_wdata = 32'h11111111; req_funct3 = 3'b010;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("mid_wait_ready", 32'(req_ready), 32'd0);
        #2 reset = 1'b0;
        #1;
        chk("arst_ready", 32'(req_ready), 32'd1);
        chk("arst_valid", 32'(rsp_valid), 32'd0);
        chk("arst_data",  rsp_rdata, 32'd0);
        chk("arst_err",   32'(rsp_err), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        xact("lw20_after", 0, 32'h20, 32'd0, 3'b010, 32'd0, 0, 0);

        chk("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
